// File: rtl/and_sched_pkg.sv
// Shared widths and types for the round-robin AND scheduler.
package and_sched_pkg;

  localparam int N_DEF = 8;
  localparam int M_DEF = 4;
  localparam int IDW   = $clog2(M_DEF);

  typedef logic [N_DEF-1:0] word_t;
  typedef logic [IDW-1:0]   id_t;

endpackage

// File: rtl/and_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first valid index at or after ptr wins,
// searching upward and wrapping from M-1 to 0.
module rr_arbiter #(
  parameter  int M    = 4,
  localparam int ID_W = $clog2(M)
) (
  input  logic [M-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [M-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < M; k++) begin
      idx = (int'(ptr) + k) % M;
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
    // gnt is qualified by en; any and gnt_id report the candidate regardless.
    if (en && any) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/and_sched.sv
// Round-robin scheduler sharing one registered N-bit AND among M requesters,
// with a single valid/ready response port and a saturating completion counter.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_EMPTY | result register empty, rsp_valid = 0
//   ST_FULL  | result register holds a result, rsp_valid = 1
module and_sched
  import and_sched_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int M    = M_DEF,
  localparam int RID_W = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [M-1:0]         req_valid,
  output logic [M-1:0]         req_ready,
  input  logic [M-1:0][N-1:0]  req_a,
  input  logic [M-1:0][N-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_c,
  output logic [RID_W-1:0]     rsp_id,
  output logic [15:0]          done_cnt
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       rsp_c_q, rsp_c_d;
  logic [RID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [RID_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        done_q, done_d;

  logic               can_accept;
  logic               grant;
  logic               any;
  logic [M-1:0]       gnt;
  logic [RID_W-1:0]   gnt_id;

  // rst_n gates acceptance so req_ready stays low for the whole reset.
  assign can_accept = rst_n && ((state_q == ST_EMPTY) || rsp_ready);
  assign grant      = can_accept && any;

  rr_arbiter #(.M(M)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (can_accept),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  always_comb begin
    state_d  = state_q;
    rsp_c_d  = rsp_c_q;
    rsp_id_d = rsp_id_q;
    ptr_d    = ptr_q;
    done_d   = done_q;

    case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (grant) begin
      rsp_c_d  = req_a[gnt_id] & req_b[gnt_id];
      rsp_id_d = gnt_id;
      ptr_d    = (int'(gnt_id) == M - 1) ? '0 : gnt_id + 1'b1;
    end

    if ((state_q == ST_FULL) && rsp_ready && (done_q != 16'hFFFF))
      done_d = done_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rsp_c_q  <= '0;
      rsp_id_q <= '0;
      ptr_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rsp_c_q  <= rsp_c_d;
      rsp_id_q <= rsp_id_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_c     = rsp_c_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_and_sched.sv
// Scoreboard bench for and_sched: stimulus pushes expected results, a monitor
// pops and compares on every response handshake.
module tb_and_sched;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  req_a;
  logic [3:0][7:0]  req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_c;
  logic [1:0]       rsp_id;
  logic [15:0]      done_cnt;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  and_sched #(.N(8), .M(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] c);
    exp_t e;
    e.id = id;
    e.c  = c;
    sb.push_back(e);
  endtask

  // Monitor: a response is consumed when valid and ready are both high at the edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {22'd0, rsp_id, rsp_c}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
        chk("rsp_c", {24'd0, rsp_c}, {24'd0, e.c});
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    sb.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_id;
    logic [7:0] exp_c [4];
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;

    // Reset state, with requests present
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_c", {24'd0, rsp_c}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_done", {16'd0, done_cnt}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    cyc();
    req_valid = 4'b0000;
    rst_n = 1'b1;
    cyc();

    // Single request from 2
    rsp_ready = 1'b1;
    req_a[2] = 8'hF0; req_b[2] = 8'h3C;
    req_valid = 4'b0100;
    push(2'd2, 8'h30);
    @(negedge clk);
    chk("t1_ready", {28'd0, req_ready}, 32'b0100);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
    cyc();
    @(negedge clk);
    chk("t1_done", {16'd0, done_cnt}, 32'd1);
    chk("t1_empty", {31'd0, rsp_valid}, 32'd0);

    // All four valid from reset: 0,1,2,3,0,1,2,3
    cyc();
    do_reset();
    rsp_ready = 1'b1;
    req_a[0] = 8'hFF; req_b[0] = 8'h12; exp_c[0] = 8'h12;
    req_a[1] = 8'hF0; req_b[1] = 8'h3C; exp_c[1] = 8'h30;
    req_a[2] = 8'h0F; req_b[2] = 8'hF5; exp_c[2] = 8'h05;
    req_a[3] = 8'hAA; req_b[3] = 8'hCC; exp_c[3] = 8'h88;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_id = 2'(k % 4);
      push(exp_id, exp_c[k % 4]);
      @(negedge clk);
      chk("t2_ready", {28'd0, req_ready}, 32'(1 << (k % 4)));
      if (k > 0) chk("t2_thru", {31'd0, rsp_valid}, 32'd1);
      cyc();
    end
    req_valid = 4'b0000;
    cyc();
    @(negedge clk);
    chk("t2_done", {16'd0, done_cnt}, 32'd8);

    // Backpressure: hold AA for 5 cycles, queued request from 1 waits
    rsp_ready = 1'b0;
    req_a[0] = 8'hAA; req_b[0] = 8'hFF;
    req_valid = 4'b0001;
    push(2'd0, 8'hAA);
    cyc();
    req_a[1] = 8'h5A; req_b[1] = 8'h0F;
    req_valid = 4'b0010;
    push(2'd1, 8'h0A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_ready", {28'd0, req_ready}, 32'd0);
      chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t3_hold_c", {24'd0, rsp_c}, 32'hAA);
      chk("t3_hold_id", {30'd0, rsp_id}, 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", {28'd0, req_ready}, 32'b0010);
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t3_next_valid", {31'd0, rsp_valid}, 32'd1);
    cyc();

    // Pointer wrap: grant 3, then 0 and 1 valid
    req_a[3] = 8'hC3; req_b[3] = 8'hFF;
    req_valid = 4'b1000;
    push(2'd3, 8'hC3);
    cyc();
    req_a[0] = 8'h81; req_b[0] = 8'hFF;
    req_a[1] = 8'h7E; req_b[1] = 8'h3C;
    req_valid = 4'b0011;
    push(2'd0, 8'h81);
    push(2'd1, 8'h3C);
    @(negedge clk);
    chk("t4_wrap_ready", {28'd0, req_ready}, 32'b0001);
    cyc();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t4_second_ready", {28'd0, req_ready}, 32'b0010);
    cyc();
    req_valid = 4'b0000;
    cyc();

    // Reset while FULL
    rsp_ready = 1'b0;
    req_a[2] = 8'hF0; req_b[2] = 8'h3C;
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_full", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_rst_c", {24'd0, rsp_c}, 32'd0);
    chk("t5_rst_done", {16'd0, done_cnt}, 32'd0);
    sb.delete();
    req_a[1] = 8'h3C; req_b[1] = 8'h0F;
    req_a[3] = 8'hFF; req_b[3] = 8'hFF;
    req_valid = 4'b1010;
    cyc();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    push(2'd1, 8'h0C);
    push(2'd3, 8'hFF);
    @(negedge clk);
    chk("t5_first_ready", {28'd0, req_ready}, 32'b0010);
    cyc();
    req_valid = 4'b1000;
    cyc();
    req_valid = 4'b0000;
    cyc();
    @(negedge clk);
    chk("t5_done", {16'd0, done_cnt}, 32'd2);

    // Saturation: 65534 streamed transfers, then 3 more
    cyc();
    do_reset();
    rsp_ready = 1'b1;
    req_a[0] = 8'hFF; req_b[0] = 8'h12;
    req_a[1] = 8'hF0; req_b[1] = 8'h3C;
    req_a[2] = 8'h0F; req_b[2] = 8'hF5;
    req_a[3] = 8'hAA; req_b[3] = 8'hCC;
    req_valid = 4'b1111;
    for (int k = 0; k < 65534; k++) begin
      push(2'(k % 4), exp_c[k % 4]);
      cyc();
    end
    req_valid = 4'b0000;
    cyc();
    @(negedge clk);
    chk("t6_preload", {16'd0, done_cnt}, 32'hFFFE);
    // pointer now at 65534 mod 4 = 2
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b1111;
      push(2'((2 + k) % 4), exp_c[(2 + k) % 4]);
      cyc();
      req_valid = 4'b0000;
      cyc();
      @(negedge clk);
      chk("t6_sat", {16'd0, done_cnt}, 32'hFFFF);
    end

    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
